fp_pack_normalizer: RTL and testbench
=====================================

FP_PACK_NORMALIZER -- requirements
Module: fp_pack_normalizer

Interface
REQ-001 Parameters: none; fixed IEEE-754 single precision, bias 127.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand offered.
REQ-005 in_ready  output  1  block can accept.
REQ-006 in_sign  input  1  result sign.
REQ-007 in_exp  input  8  biased exponent of in_man, legal range 1..254.
REQ-008 in_man  input  27  raw magnitude: bit26 carry, bit25 hidden, bits24:2 fraction, bit1 guard, bit0 sticky.
REQ-009 out_valid  output  1  packed result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_word  output  32  {sign, exp[7:0], frac[22:0]}.
REQ-012 out_flags  output  3  {overflow, underflow, zero}.

Function
REQ-013 FSM states IDLE, ALIGN, NORM, ROUND, DONE; internal exponent 9 bits unsigned, mantissa register 27 bits.
REQ-014 in_ready = 1 only in IDLE and reset low; transfer when in_valid & in_ready; inputs captured, IDLE -> ALIGN.
REQ-015 ALIGN: if in_man == 0 -> result {sign,31'b0}, zero flag, -> DONE.
REQ-016 ALIGN: if bit26 = 1 -> mantissa >> 1, bit0 = old bit1 | old bit0 (sticky), exp + 1; then -> NORM.
REQ-017 ALIGN: if exp after carry >= 255 -> result {sign,8'hFF,23'b0}, overflow flag, -> DONE.
REQ-018 NORM: one cycle per step; if bit25 = 1 -> ROUND; else if exp == 1 -> result {sign,31'b0}, underflow flag, -> DONE (flush, no denormals); else mantissa << 1 (bit0 stays sticky, zero shifted into bit1 position), exp - 1.
REQ-019 ROUND: round-to-nearest-even: increment at bit2 when guard & (sticky | bit2).
REQ-020 ROUND: if increment carries into bit26 -> mantissa >> 1, exp + 1; if exp then >= 255 -> infinity pattern of REQ-017, overflow flag.
REQ-021 ROUND: otherwise out_word = {sign, exp[7:0], mantissa[24:2]}, flags 000; -> DONE.
REQ-022 DONE: out_valid = 1, out_word/out_flags stable until out_ready sampled high; that edge -> IDLE, out_valid 0 next cycle.
REQ-023 Latency: k = leading zeros above bit25 after ALIGN (0..25); out_valid high in cycle 4+k after accept edge; zero input: cycle 2.
REQ-024 No new operand accepted while busy or in DONE; no pipelining, one operation in flight.
REQ-025 out_valid, out_word, out_flags registered; only in_ready derived combinationally from state and reset.
REQ-026 in_exp = 0 with nonzero in_man treated as exp 1 (flushes via REQ-018 if unnormalized).

Reset
REQ-027 reset high at a clock edge: state IDLE, out_valid 0, out_word 0, out_flags 0, internal registers 0.
REQ-028 Reset mid-operation (any state incl. DONE) aborts; result discarded, no out_valid pulse.
REQ-029 in_ready low whenever reset high; in_valid ignored during reset.

Verification
REQ-030 Carry: sign0, exp127, man 27'h4000000 -> out_word 32'h40000000, flags 000.
REQ-031 Normalized/latency: sign0, exp127, man 27'h3000000 -> 32'h3FC00000, out_valid cycle 4; man 27'h0800000 -> 32'h3E800000, out_valid cycle 6.
REQ-032 Round carry: exp127, man 27'h3FFFFFE -> 32'h40000000; man 27'h3FFFFFC (guard 0) -> 32'h3FFFFFFF.
REQ-033 Overflow/zero: exp254, man 27'h4000000 -> 32'h7F800000, flags 100; sign1, man 0 -> 32'h80000000, flags 001, cycle 2.
REQ-034 Underflow: exp1, man 27'h1000000 -> 32'h00000000, flags 010.
REQ-035 Handshake/reset: hold out_ready low 5 cycles -> output stable, in_ready 0; assert reset during NORM -> next cycle out_valid 0, in_ready 1 after reset drops.

Source files
------------

// File: rtl/fp_pack_normalizer_if.sv
// Operand/result handshake bundle for the single-precision pack/normalize block.
// The master offers raw operands and consumes packed words; the slave is the normalizer.
interface fp_pack_normalizer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_man;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_man, out_ready,
    input  in_ready, out_valid, out_word, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, out_ready,
    output in_ready, out_valid, out_word, out_flags
  );
endinterface

// File: rtl/fp_pack_normalizer.sv
// Normalizes, rounds (nearest-even) and packs a raw 27-bit magnitude into IEEE-754 single.
// One operation in flight; a multi-cycle FSM shifts left one bit per NORM cycle.
module fp_pack_normalizer (
  input  logic                  clk,
  input  logic                  reset,
  fp_pack_normalizer_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, ALIGN, NORM, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [8:0]  exp_q, exp_d;
  logic [26:0] man_q, man_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic [2:0]  out_flags_q, out_flags_d;

  logic        rnd_inc;
  logic [26:0] rnd_sum;
  logic [8:0]  exp_inc;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    man_d       = man_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_flags_d = out_flags_q;

    // Round bit sits at bit2; guard is bit1, sticky is bit0.
    rnd_inc = man_q[1] & (man_q[0] | man_q[2]);
    rnd_sum = man_q + {24'd0, rnd_inc, 2'b00};
    exp_inc = exp_q + 9'd1;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sign_d  = bus.in_sign;
          exp_d   = (bus.in_exp == 8'd0) ? 9'd1 : {1'b0, bus.in_exp};
          man_d   = bus.in_man;
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        if (man_q == 27'd0) begin
          out_word_d  = {sign_q, 31'd0};
          out_flags_d = 3'b001;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (man_q[26]) begin
          if (exp_inc >= 9'd255) begin
            out_word_d  = {sign_q, 8'hFF, 23'd0};
            out_flags_d = 3'b100;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            man_d   = {1'b0, man_q[26:2], man_q[1] | man_q[0]};
            exp_d   = exp_inc;
            state_d = NORM;
          end
        end else begin
          state_d = NORM;
        end
      end

      NORM: begin
        if (man_q[25]) begin
          state_d = ROUND;
        end else if (exp_q == 9'd1) begin
          out_word_d  = {sign_q, 31'd0};
          out_flags_d = 3'b010;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          // Guard moves up into bit2, sticky stays put in bit0.
          man_d = {man_q[25:1], 1'b0, man_q[0]};
          exp_d = exp_q - 9'd1;
        end
      end

      ROUND: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (rnd_sum[26]) begin
          man_d = {1'b0, rnd_sum[26:1]};
          exp_d = exp_inc;
          if (exp_inc >= 9'd255) begin
            out_word_d  = {sign_q, 8'hFF, 23'd0};
            out_flags_d = 3'b100;
          end else begin
            out_word_d  = {sign_q, exp_inc[7:0], rnd_sum[25:3]};
            out_flags_d = 3'b000;
          end
        end else begin
          man_d       = rnd_sum;
          out_word_d  = {sign_q, exp_q[7:0], rnd_sum[24:2]};
          out_flags_d = 3'b000;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= 9'd0;
      man_q       <= 27'd0;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'd0;
      out_flags_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      man_q       <= man_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) & ~reset;
  assign bus.out_valid = out_valid_q;
  assign bus.out_word  = out_word_q;
  assign bus.out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_pack_normalizer.sv
// Scoreboard bench for fp_pack_normalizer: directed corner vectors, random operands
// checked against an arithmetic reference model, output hold and mid-operation reset.
module tb_fp_pack_normalizer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fp_pack_normalizer_if bus();

  fp_pack_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] word;
    logic [2:0]  flags;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] w, input logic [2:0] f, input int l);
    exp_t r;
    r.tag   = "";
    r.word  = w;
    r.flags = f;
    r.lat   = l;
    return r;
  endfunction

  // Arithmetic reference: normalize by counting shifts, then round on integers.
  function automatic exp_t model(input logic s, input logic [7:0] e_in, input logic [26:0] m_in);
    int          e;
    int          k;
    logic [26:0] m;
    logic [24:0] f;
    logic [7:0]  e8;
    if (m_in == 27'd0) return mk({s, 31'd0}, 3'b001, 2);
    e = (e_in == 8'd0) ? 1 : int'(e_in);
    m = m_in;
    if (m[26]) begin
      m = (m >> 1) | {26'd0, m_in[0]};
      e = e + 1;
      if (e >= 255) return mk({s, 8'hFF, 23'd0}, 3'b100, 2);
    end
    k = 0;
    while (!m[25] && e > 1) begin
      m = ((m >> 1) << 2) | {26'd0, m[0]};
      e = e - 1;
      k = k + 1;
    end
    if (!m[25]) return mk({s, 31'd0}, 3'b010, 3 + k);
    f = {1'b0, m[25:2]};
    if (m[1] && (m[0] || m[2])) f = f + 25'd1;
    if (f[24]) begin
      f = f >> 1;
      e = e + 1;
    end
    if (e >= 255) return mk({s, 8'hFF, 23'd0}, 3'b100, 4 + k);
    e8 = e[7:0];
    return mk({s, e8, f[22:0]}, 3'b000, 4 + k);
  endfunction

  task automatic run_op(input string tag, input logic s, input logic [7:0] e,
                        input logic [26:0] m, input exp_t want, input int hold);
    exp_t        got_exp;
    int          lat;
    bit          seen;
    logic [31:0] held_word;
    want.tag = tag;
    sb_q.push_back(want);
    @(negedge clk);
    bus.out_ready = (hold == 0);
    bus.in_sign   = s;
    bus.in_exp    = e;
    bus.in_man    = m;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) check($sformatf("%s/busy_ready", tag), bus.in_ready, 0);
      if (bus.out_valid) seen = 1'b1;
    end
    got_exp = sb_q.pop_front();
    if (!seen) begin
      check($sformatf("%s/timeout", got_exp.tag), 0, 1);
    end else begin
      $display("op %s: s=%0d e=%0d man=%07h -> word=%08h flags=%03b lat=%0d (exp %08h %03b %0d)",
               got_exp.tag, s, e, m, bus.out_word, bus.out_flags, lat,
               got_exp.word, got_exp.flags, got_exp.lat);
      check($sformatf("%s/word", got_exp.tag), bus.out_word, got_exp.word);
      check($sformatf("%s/flags", got_exp.tag), bus.out_flags, got_exp.flags);
      check($sformatf("%s/latency", got_exp.tag), lat, got_exp.lat);
      if (hold > 0) begin
        held_word = bus.out_word;
        bus.in_valid = 1'b1;
        bus.in_man   = 27'h2000000;
        repeat (hold) begin
          @(negedge clk);
          check($sformatf("%s/hold_valid", got_exp.tag), bus.out_valid, 1);
          check($sformatf("%s/hold_word", got_exp.tag), bus.out_word, held_word);
          check($sformatf("%s/hold_ready", got_exp.tag), bus.in_ready, 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
      end
    end
    @(negedge clk);
    check($sformatf("%s/valid_drop", got_exp.tag), bus.out_valid, 0);
    check($sformatf("%s/idle_ready", got_exp.tag), bus.in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        rs;
    logic [7:0]  re;
    logic [26:0] rm;
    int          vis;

    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd127;
    bus.in_man    = 27'h2000000;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset/in_ready", bus.in_ready, 0);
    check("reset/out_valid", bus.out_valid, 0);
    check("reset/out_word", bus.out_word, 0);
    check("reset/out_flags", bus.out_flags, 0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post_reset/in_ready", bus.in_ready, 1);
    check("post_reset/out_valid", bus.out_valid, 0);

    run_op("carry",       1'b0, 8'd127, 27'h4000000, mk(32'h40000000, 3'b000, 4), 0);
    run_op("norm_k0",     1'b0, 8'd127, 27'h3000000, mk(32'h3FC00000, 3'b000, 4), 0);
    run_op("norm_k2",     1'b0, 8'd127, 27'h0800000, mk(32'h3E800000, 3'b000, 6), 0);
    run_op("round_carry", 1'b0, 8'd127, 27'h3FFFFFE, mk(32'h40000000, 3'b000, 4), 0);
    run_op("guard0",      1'b0, 8'd127, 27'h3FFFFFC, mk(32'h3FFFFFFF, 3'b000, 4), 0);
    run_op("overflow",    1'b0, 8'd254, 27'h4000000, mk(32'h7F800000, 3'b100, 2), 0);
    run_op("zero_neg",    1'b1, 8'd127, 27'h0000000, mk(32'h80000000, 3'b001, 2), 0);
    run_op("underflow",   1'b0, 8'd1,   27'h1000000, mk(32'h00000000, 3'b010, 3), 0);
    run_op("exp0_norm",   1'b0, 8'd0,   27'h2000000, mk(32'h00800000, 3'b000, 4), 0);
    run_op("rne_tie_even",1'b0, 8'd127, 27'h2000002, mk(32'h3F800000, 3'b000, 4), 0);
    run_op("round_ovf",   1'b1, 8'd254, 27'h3FFFFFE, mk(32'hFF800000, 3'b100, 4), 0);
    run_op("hold",        1'b0, 8'd127, 27'h3000000, mk(32'h3FC00000, 3'b000, 4), 5);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      re = (i % 4 == 3) ? 8'($urandom_range(1, 20)) : 8'($urandom_range(1, 254));
      rm = 27'($urandom) >> $urandom_range(0, 26);
      if (i % 6 == 5) rm = rm | 27'h4000000;
      run_op($sformatf("rand%0d", i), rs, re, rm, model(rs, re, rm), 0);
    end

    // Abort an operation while it is still shifting in NORM.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_sign   = 1'b0;
    bus.in_exp    = 8'd127;
    bus.in_man    = 27'h0000100;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("midreset/out_valid", bus.out_valid, 0);
    check("midreset/in_ready", bus.in_ready, 0);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("midreset/ready_after", bus.in_ready, 1);
    vis = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) vis++;
    end
    check("midreset/no_result", vis, 0);
    check("midreset/scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
